// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;
    localparam int BYTE_W           = 8;
    localparam int WORD_W           = 16;
    localparam int COUNT_ZERO_WORDS = 256;

    typedef enum logic [3:0] {
        IDLE, COUNT, HI, LO, WRITE, CHECK, RELEASE, DONE, ERROR
    } state_t;
endpackage

// File: rtl/loader_release_timer.sv
// Loadable down-counter with a zero flag; paces the CPU reset release.
module loader_release_timer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                     cnt_q <= '0;
        else if (load_i)               cnt_q <= load_val_i;
        else if (en_i && cnt_q != '0)  cnt_q <= cnt_q - W'(1);
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/program_loader.sv
// Byte-stream to 16-bit RAM image loader that holds the CPU in reset until loaded.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte with an ERROR state.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int BASE_ADR      = 0,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_wadr,
    output logic [WORD_W-1:0] ram_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int CNT_W = $clog2(COUNT_ZERO_WORDS) + 1;
    localparam int TW    = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY);
    // RELEASE itself occupies the first delay cycle, so the timer is loaded one short.
    localparam int TLOAD = (RELEASE_DELAY == 0) ? 0 : RELEASE_DELAY - 1;

    state_t            state_q;
    logic [CNT_W-1:0]  n_q, idx_q;
    logic [BYTE_W-1:0] hi_q;
    logic              ram_we_q, cpu_reset_q, busy_q, done_q;
    logic [ADDR_W-1:0] ram_wadr_q;
    logic [WORD_W-1:0] ram_wdata_q;
    logic              xfer, last_word, enter_release, tmr_zero;

    assign rx_ready  = state_q inside {COUNT, HI, LO, CHECK};
    assign xfer      = rx_valid && rx_ready;
    assign last_word = (idx_q + CNT_W'(1)) == n_q;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;
    logic              error_q;

    assign enter_release = (state_q == CHECK) && xfer && (rx_data == xor_q);
    assign error         = error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q   <= '0;
            error_q <= 1'b0;
        end else if (start && state_q inside {IDLE, DONE, ERROR}) begin
            xor_q   <= '0;
            error_q <= 1'b0;
        end else if (xfer && state_q != CHECK) begin
            xor_q <= xor_q ^ rx_data;
        end else if (xfer && rx_data != xor_q) begin
            error_q <= 1'b1;
        end
    end
`else
    assign enter_release = (state_q == WRITE) && last_word;
    assign error         = 1'b0;
`endif

    loader_release_timer #(.W(TW)) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (enter_release),
        .load_val_i (TW'(TLOAD)),
        .en_i       (state_q == RELEASE),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            ram_we_q    <= 1'b0;
            ram_wadr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ram_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: if (start) begin
                    state_q     <= COUNT;
                    idx_q       <= '0;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    cpu_reset_q <= 1'b1;
                end
                COUNT: if (xfer) begin
                    n_q     <= (rx_data == '0) ? CNT_W'(COUNT_ZERO_WORDS) : CNT_W'(rx_data);
                    state_q <= HI;
                end
                HI: if (xfer) begin
                    hi_q    <= rx_data;
                    state_q <= LO;
                end
                LO: if (xfer) begin
                    ram_we_q    <= 1'b1;
                    ram_wadr_q  <= ADDR_W'(BASE_ADR) + ADDR_W'(idx_q);
                    ram_wdata_q <= {hi_q, rx_data};
                    state_q     <= WRITE;
                end
                WRITE: begin
                    idx_q <= idx_q + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
                    state_q <= last_word ? CHECK : HI;
`else
                    state_q <= last_word ? RELEASE : HI;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (xfer) begin
                    if (enter_release) state_q <= RELEASE;
                    else begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                RELEASE: if (tmr_zero) begin
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cpu_reset_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_wadr  = ram_wadr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0x00 and 0xF0) against a transaction-level model.
module tb_program_loader;
    localparam int RD = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam int LAT = RD + 2;
`else
    localparam int LAT = RD + 1;
`endif

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ready, ram_we, cpu_reset, busy, done, error;
    logic [7:0] ram_wadr;
    logic [15:0] ram_wdata;
    logic w_rx_ready, w_ram_we, w_cpu_reset, w_busy, w_done, w_error;
    logic [7:0] w_ram_wadr;
    logic [15:0] w_ram_wdata;

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(8), .BASE_ADR(0), .RELEASE_DELAY(RD)) u_dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .ram_we(ram_we), .ram_wadr(ram_wadr), .ram_wdata(ram_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error));

    program_loader #(.ADDR_W(8), .BASE_ADR(8'hF0), .RELEASE_DELAY(RD)) u_dut_w (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(w_rx_ready), .ram_we(w_ram_we), .ram_wadr(w_ram_wadr), .ram_wdata(w_ram_wdata),
        .cpu_reset(w_cpu_reset), .busy(w_busy), .done(w_done), .error(w_error));

    typedef logic [7:0] bq_t[$];
    typedef struct { logic [7:0] a0; logic [7:0] aw; logic [15:0] d; } wr_t;
    typedef struct { int cyc; logic [7:0] a0; logic [7:0] aw; logic [15:0] d; } log_t;

    int tests = 0, fails = 0, cyc = 0;
    wr_t  exp_q[$];
    log_t wlog[$];
    int sess_cyc = -1, rel_cyc = -1, err_cyc = -1, done_rise = -1;
    logic [7:0] last_a0 = 8'h00, last_aw = 8'h00;
    logic [15:0] last_d = 16'h0000;
    bit chk_en = 1'b0;
    bit done_e, err_e, busy_e;
    wr_t cur;
    log_t lg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] xsum(input bq_t q);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    // Cycle-level compare of both instances against the model.
    always @(negedge clk) if (chk_en) begin
        done_e = rel_cyc >= 0 && cyc >= rel_cyc + RD + 1;
        err_e  = err_cyc >= 0 && cyc >= err_cyc + 1;
        busy_e = sess_cyc >= 0 && cyc >= sess_cyc && !done_e && !err_e;
        if (ram_we) begin
            if (exp_q.size() == 0) check("spurious_we", ram_we, 1'b0);
            else begin
                cur = exp_q.pop_front();
                last_a0 = cur.a0; last_aw = cur.aw; last_d = cur.d;
                lg.cyc = cyc; lg.a0 = ram_wadr; lg.aw = w_ram_wadr; lg.d = ram_wdata;
                wlog.push_back(lg);
`ifndef LOADER_CHECKSUM_EN
                if (exp_q.size() == 0) rel_cyc = cyc;
`endif
            end
        end
        check("we_pair", w_ram_we, ram_we);
        check("wadr", ram_wadr, last_a0);
        check("wadr_w", w_ram_wadr, last_aw);
        check("wdata", ram_wdata, last_d);
        check("wdata_w", w_ram_wdata, last_d);
        check("done", done, done_e);
        check("done_w", w_done, done_e);
        check("cpu_reset", cpu_reset, !done_e);
        check("cpu_reset_w", w_cpu_reset, !done_e);
        check("busy", busy, busy_e);
        check("busy_w", w_busy, busy_e);
        check("error", error, err_e);
        check("error_w", w_error, err_e);
        if (!busy_e) check("rx_ready_idle", rx_ready | w_rx_ready, 1'b0);
        if (done && done_rise < 0) done_rise = cyc;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        sess_cyc = -1; rel_cyc = -1; err_cyc = -1; done_rise = -1;
        last_a0 = 8'h00; last_aw = 8'h00; last_d = 16'h0000;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        tick();
        clear_model();
        repeat (n - 1) tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        sess_cyc = cyc; rel_cyc = -1; err_cyc = -1; done_rise = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc = -1;
        rx_data = b; rx_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = rx_ready;
            acc_cyc = cyc;
            tick();
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL rx_timeout: byte %h not accepted within 20 cycles", b);
        end
    endtask

    task automatic send_image(input bq_t img, input int max_gap, input bit poke, input bit corrupt);
        int n, acc;
        wr_t w;
        n = (img[0] == 8'h00) ? 256 : int'(img[0]);
        for (int k = 0; k < n; k++) begin
            w.a0 = 8'(k); w.aw = 8'(240 + k); w.d = {img[1 + 2*k], img[2 + 2*k]};
            exp_q.push_back(w);
        end
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], acc);
            if (max_gap > 0) begin
                start = poke && (i < img.size() - 1);
                tick();
                start = 1'b0;
                repeat ($urandom_range(1, max_gap) - 1) tick();
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(corrupt ? 8'h00 : xsum(img), acc);
        if (corrupt) err_cyc = acc; else rel_cyc = acc;
`else
        if (corrupt) $display("note: checksum corruption has no effect in this build");
`endif
    endtask

    task automatic wait_end();
        int t = 0;
        while (t < 100 && !(done || error)) begin tick(); t++; end
        if (!(done || error)) begin
            tests++; fails++;
            $display("FAIL end_timeout: neither done nor error after 100 cycles");
        end
        repeat (3) tick();
    endtask

    bq_t img;
    int acc;

    initial begin
        // Reset held three cycles
        do_reset(3);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_wadr", ram_wadr, 8'h00);
        check("rst_wdata", ram_wdata, 16'h0000);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_cpu_reset_w", w_cpu_reset, 1'b1);
        chk_en = 1'b1;
        tick();

        // Two words back-to-back
        wlog.delete();
        do_start();
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_image(img, 0, 1'b0, 1'b0);
        wait_end();
        check("b2b_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("b2b_w0", {wlog[0].a0, wlog[0].d}, 24'h00_1234);
            check("b2b_w1", {wlog[1].a0, wlog[1].d}, 24'h01_ABCD);
            check("b2b_w0_base_f0", wlog[0].aw, 8'hF0);
            check("b2b_throughput", wlog[1].cyc - wlog[0].cyc, 3);
            check("b2b_done_latency", done_rise - wlog[1].cyc, LAT);
        end

        // Same stream with gaps; start pulses mid-stream must be ignored
        wlog.delete();
        do_start();
        send_image(img, 4, 1'b1, 1'b0);
        wait_end();
        check("gap_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) check("gap_w1", {wlog[1].a0, wlog[1].d}, 24'h01_ABCD);

        // 256 words, wrap from 0xFF to 0x00 on the 0xF0-based instance
        wlog.delete();
        img.delete();
        img.push_back(8'h00);
        for (int j = 0; j < 512; j++) img.push_back(8'(j) ^ 8'h5A);
        do_start();
        send_image(img, 0, 1'b0, 1'b0);
        wait_end();
        check("wrap_nwrites", wlog.size(), 256);
        if (wlog.size() == 256) begin
            check("wrap_first", wlog[0].aw, 8'hF0);
            check("wrap_15", wlog[15].aw, 8'hFF);
            check("wrap_16", {wlog[16].aw, wlog[16].a0, wlog[16].d}, 32'h00_10_7A7B);
            check("wrap_last", wlog[255].aw, 8'hEF);
        end

        // Reset one cycle after the first write of a 4-word load
        do_start();
        cur.a0 = 8'h00; cur.aw = 8'hF0; cur.d = 16'h1122;
        exp_q.push_back(cur);
        send_byte(8'h04, acc);
        send_byte(8'h11, acc);
        send_byte(8'h22, acc);
        tick();
        reset = 1'b1;
        tick();
        clear_model();
        reset = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_wadr", ram_wadr, 8'h00);
        wlog.delete();
        do_start();
        img = '{8'h01, 8'h55, 8'hAA};
        send_image(img, 0, 1'b0, 1'b0);
        wait_end();
        check("reload_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) check("reload_w0", {wlog[0].a0, wlog[0].d}, 24'h00_55AA);
        check("reload_done", done, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        img = '{8'h01, 8'h12, 8'h34};
        check("ck_model", xsum(img), 8'h27);
        do_start();
        send_image(img, 0, 1'b0, 1'b0);
        wait_end();
        check("ck_good_done", done, 1'b1);
        do_start();
        send_image(img, 0, 1'b0, 1'b1);
        wait_end();
        check("ck_bad_error", error, 1'b1);
        check("ck_bad_cpu_reset", cpu_reset, 1'b1);
        check("ck_bad_done", done, 1'b0);
        do_start();
        send_image(img, 2, 1'b0, 1'b0);
        wait_end();
        check("ck_recover_done", done, 1'b1);
        check("ck_recover_error", error, 1'b0);
`endif

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage upstream of the 16-bit CPU.
- Receives a byte stream over a valid/ready handshake and packs each pair of bytes (high byte first) into a 16-bit instruction/data word.
- Writes each word into the CPU's 256x16 RAM through a write port.
- Holds the CPU in reset until the whole image is loaded, then releases it after a programmable delay.

Parameters:
ADDR_W, 8, RAM address width; word addresses wrap modulo 2^ADDR_W
BASE_ADR, 0, RAM address of the first loaded word
RELEASE_DELAY, 2, cycles in RELEASE before cpu_reset deasserts (0 allowed)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a load session
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid; sender holds the byte until it is accepted
rx_ready  output  1  loader can accept a byte this cycle
ram_we  output  1  RAM write strobe, one cycle per word
ram_wadr  output  ADDR_W  RAM write address
ram_wdata  output  16  RAM write data
cpu_reset  output  1  reset to the CPU (its clk/reset domain), active-high
busy  output  1  load session in progress
done  output  1  image loaded, CPU released (sticky)
error  output  1  checksum failure (sticky; see Optional Feature)

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE; rx_ready=0, ram_we=0, ram_wadr=0, ram_wdata=0, cpu_reset=1, busy=0, done=0, error=0. Internal counters and checksum are cleared.
- Byte transfer: occurs on a rising edge where rx_valid && rx_ready. rx_ready is a combinational decode of state: it is 1 only in COUNT, HI, LO and CHECK.
- States and transitions:
  - IDLE: start -> COUNT.
  - COUNT: an accepted byte sets N (word count); N=0 means 256. Go to HI.
  - HI: an accepted byte becomes the high byte. Go to LO.
  - LO: an accepted byte becomes the low byte. Go to WRITE.
  - WRITE: ram_we=1 for exactly this cycle, ram_wadr=BASE_ADR+idx (mod 2^ADDR_W), ram_wdata={hi,lo}; idx++. If the word just written is the last (idx reaches N), go to CHECK when the feature is enabled, otherwise RELEASE. If not the last, go to HI.
  - RELEASE: down-counter runs for RELEASE_DELAY cycles, then DONE. With RELEASE_DELAY=0 it goes to DONE on the next edge.
  - DONE: cpu_reset=0, done=1. start -> COUNT; on that same edge cpu_reset goes to 1 and done goes to 0.
  - start is ignored in every state except IDLE, DONE and ERROR.
- Latency and throughput:
  - ram_we asserts in the cycle after the low-byte transfer edge.
  - Minimum throughput is 3 cycles per word.
  - done=1 and cpu_reset=0 first appear RELEASE_DELAY+1 cycles after the last ram_we cycle (feature disabled).
- busy=1 in COUNT, HI, LO, WRITE, CHECK and RELEASE; otherwise 0.
- ram_wadr and ram_wdata hold their last values when ram_we=0.
- cpu_reset=1 in every state except DONE.
- Backpressure: gaps in rx_valid stall the FSM in place. No byte is dropped or duplicated.
- Address wrap: with BASE_ADR+N > 2^ADDR_W, writes wrap to address 0. No error is raised.
- Reset mid-load: all outputs return to their reset values immediately on the edge. RAM words already written stay in place. A later start reloads from scratch.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CHECK accepts one byte and compares it to the running XOR of the count byte and every data byte.
  - Match -> RELEASE.
  - Mismatch -> ERROR: error=1, busy=0, cpu_reset=1. ERROR exits only via start (-> COUNT, error cleared) or reset.
- Undefined: no CHECK or ERROR states, no XOR register, error tied to 0.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, COUNT, HI, LO, WRITE, CHECK, RELEASE, DONE, ERROR);
  - BYTE_W=8 and WORD_W=16;
  - the constant COUNT_ZERO_WORDS=256.
- One sub-module, loader_release_timer: a loadable down-counter with a zero flag, used for RELEASE_DELAY.
- Everything else stays in program_loader.

Test Plan:
- Reset held 3 cycles -> every output equals its reset value; cpu_reset=1, rx_ready=0.
- start, then bytes 02,12,34,AB,CD streamed back-to-back (BASE_ADR=0, RELEASE_DELAY=2) -> single-cycle writes 0x00<-0x1234 and 0x01<-0xABCD; done=1 and cpu_reset=0 exactly 3 cycles after the second ram_we.
- Same stream with rx_valid low for 1-4 random cycles between bytes -> identical writes, no extra ram_we pulses.
- BASE_ADR=0xF0, count byte 00 followed by 512 bytes -> 256 writes at addresses F0..FF then 00..EF, in that order.
- Reset asserted one cycle after the first ram_we of a 4-word load -> next cycle in IDLE with cpu_reset=1 and busy=0; a new start with 01,55,AA writes 0x00<-0x55AA and completes.
- LOADER_CHECKSUM_EN defined: 01,12,34,27 -> done=1; 01,12,34,00 -> error=1, cpu_reset stays 1, done=0.
